sram_port_arbiter: RTL

- Shares one single-port SRAM between NUM_REQ requesters, e.g. the matcher vocab/input read paths and the encoder output write path.
- Uses round-robin arbitration with an optional bounded lock, so one requester can own the port for a burst such as a token copy.
- Sits between the requesters and the sram instance. Drives the SRAM cs/we/addr/din signals and routes the read data back with a per-requester valid pulse.

---
 rtl/sram_arb_pkg.sv | 8 +
 rtl/rr_pick.sv | 28 ++
 rtl/sram_port_arbiter.sv | 89 ++++++++
 3 files changed

// File: rtl/sram_arb_pkg.sv
// sram_arb_pkg: shared state type and pointer helper for the SRAM port arbiter
package sram_arb_pkg;
    typedef enum logic {ARB, OWN} arb_state_t;

    function automatic int next_ptr(input int i, input int n);
        return (i + 1 >= n) ? 0 : i + 1;
    endfunction
endpackage

// File: rtl/rr_pick.sv
// rr_pick: combinational rotating-priority picker, first request at or after ptr wins
module rr_pick #(
    parameter int N  = 3,
    parameter int PW = 2
) (
    input  logic [N-1:0]  req,
    input  logic [PW-1:0] ptr,
    output logic [N-1:0]  gnt,
    output logic [PW-1:0] idx
);
    int j;

    // scan from the farthest offset down so the closest requester overwrites
    always_comb begin
        gnt = '0;
        idx = '0;
        j = 0;
        for (int k = N - 1; k >= 0; k--) begin
            j = int'(ptr) + k;
            j = (j >= N) ? j - N : j;
            if (req[j]) begin
                gnt = '0;
                gnt[j] = 1'b1;
                idx = PW'(j);
            end
        end
    end
endmodule

// File: rtl/sram_port_arbiter.sv
// sram_port_arbiter: round-robin single-port SRAM sharing with bounded burst lock
module sram_port_arbiter
    import sram_arb_pkg::*;
#(
    parameter int ADDR_WIDTH = 4,
    parameter int DATA_WIDTH = 8,
    parameter int NUM_REQ    = 3,
    parameter int MAX_LOCK   = 8
) (
    input  logic                           clk,
    input  logic                           rst_n,
    input  logic [NUM_REQ-1:0]             req,
    input  logic [NUM_REQ-1:0]             we_req,
    input  logic [NUM_REQ-1:0]             lock,
    input  logic [NUM_REQ*ADDR_WIDTH-1:0]  addr_req,
    input  logic [NUM_REQ*DATA_WIDTH-1:0]  wdata_req,
    output logic [NUM_REQ-1:0]             gnt,
    output logic [NUM_REQ-1:0]             rvalid,
    output logic [DATA_WIDTH-1:0]          rdata,
    output logic                           busy,
    output logic                           mem_cs,
    output logic                           mem_we,
    output logic [ADDR_WIDTH-1:0]          mem_addr,
    output logic [DATA_WIDTH-1:0]          mem_din,
    input  logic [DATA_WIDTH-1:0]          mem_dout
);
    localparam int PW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
    localparam int CW = $clog2(MAX_LOCK) + 1;

    arb_state_t    state, state_nx;
    logic [PW-1:0] ptr, ptr_nx, owner, owner_nx, gidx, pick_idx;
    logic [CW-1:0] cnt, cnt_nx;
    logic [NUM_REQ-1:0] pick_gnt;
    logic          rel;

    rr_pick #(.N(NUM_REQ), .PW(PW)) u_pick (
        .req (req),
        .ptr (ptr),
        .gnt (pick_gnt),
        .idx (pick_idx)
    );

    always_comb begin
        rel      = !req[owner] || !lock[owner] || cnt == CW'(MAX_LOCK - 1);
        gnt      = !rst_n ? '0 : (state == OWN) ? (NUM_REQ'(req[owner]) << owner) : pick_gnt;
        gidx     = (state == OWN) ? owner : pick_idx;
        mem_cs   = |gnt;
        mem_we   = mem_cs & we_req[gidx];
        mem_addr = mem_cs ? addr_req[int'(gidx)*ADDR_WIDTH +: ADDR_WIDTH] : '0;
        mem_din  = mem_cs ? wdata_req[int'(gidx)*DATA_WIDTH +: DATA_WIDTH] : '0;
        state_nx = state;
        ptr_nx   = ptr;
        cnt_nx   = cnt;
        owner_nx = owner;
        if (state == ARB) begin
            if (|pick_gnt && lock[pick_idx]) begin
                state_nx = OWN;
                owner_nx = pick_idx;
                cnt_nx   = CW'(1);
            end else if (|pick_gnt) begin
                ptr_nx = PW'(next_ptr(int'(pick_idx), NUM_REQ));
            end
        end else if (rel) begin
            state_nx = ARB;
            ptr_nx   = PW'(next_ptr(int'(owner), NUM_REQ));
        end else begin
            cnt_nx = cnt + CW'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state  <= ARB;
            ptr    <= '0;
            cnt    <= '0;
            owner  <= '0;
            rvalid <= '0;
        end else begin
            state  <= state_nx;
            ptr    <= ptr_nx;
            cnt    <= cnt_nx;
            owner  <= owner_nx;
            rvalid <= gnt & ~we_req;
        end
    end

    assign busy  = (state == OWN);
    assign rdata = mem_dout;
endmodule
